// File: rtl/mult8_inv_divider_pkg.sv
// rtl/mult8_inv_divider_pkg.sv - shared types and constants for the inverse-product divider
package mult8_inv_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEF_N            = 8;
    localparam int DEF_BITS_PER_CYC = 2;
    localparam int DEF_ITERS        = DEF_N / DEF_BITS_PER_CYC;

    // Quotient reported on divide-by-zero or overflow.
    localparam logic [DEF_N-1:0] QUOT_SAT = '1;

    function automatic int iter_count(input int n, input int bits_per_cyc);
        return n / bits_per_cyc;
    endfunction

endpackage

// File: rtl/mult8_inv_divider_step.sv
// rtl/mult8_inv_divider_step.sv - one combinational restoring division step
module div_restore_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    logic [N:0] w_shifted;
    logic [N:0] w_diff;
    logic       w_ge;

    // N+1 bits so the bit shifted out of the partial remainder is kept for the compare.
    assign w_shifted = {i_rem, i_bit};
    assign w_ge      = (w_shifted >= {1'b0, i_divisor});
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_qbit    = w_ge;
    assign o_rem     = w_ge ? w_diff[N-1:0] : w_shifted[N-1:0];

endmodule

// File: rtl/mult8_inv_divider.sv
// rtl/mult8_inv_divider.sv - 2N/N unsigned restoring divider, BITS_PER_CYC quotient bits per cycle
module mult8_inv_divider
    import mult8_inv_divider_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int BITS_PER_CYC = DEF_BITS_PER_CYC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           err_div0,
    output logic           err_ovf
);

    localparam int ITERS = iter_count(N, BITS_PER_CYC);
    localparam int CNT_W = $clog2(ITERS + 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_shift;
    logic [N-1:0]     r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_div0;
    logic             r_err_ovf;

    logic [N-1:0]            w_rem [BITS_PER_CYC+1];
    logic [BITS_PER_CYC-1:0] w_qbits;
    logic [N-1:0]            w_shift_next;
    logic                    w_accept;
    logic                    w_div0;
    logic                    w_ovf;

    assign w_rem[0] = r_rem;

    genvar g;
    generate
        for (g = 0; g < BITS_PER_CYC; g++) begin : g_step
            div_restore_step #(.N(N)) u_step (
                .i_rem     (w_rem[g]),
                .i_bit     (r_shift[N-1-g]),
                .i_divisor (r_div),
                .o_rem     (w_rem[g+1]),
                .o_qbit    (w_qbits[BITS_PER_CYC-1-g])
            );
        end
    endgenerate

    // r_shift doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
    assign w_shift_next = (r_shift << BITS_PER_CYC) | N'(w_qbits);
    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_div0       = (divisor == '0);
    assign w_ovf        = (dividend[2*N-1:N] >= divisor);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = (w_div0 || w_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_W'(ITERS - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_err_div0 <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_div <= divisor;
            r_cnt <= '0;
            if (w_div0 || w_ovf) begin
                r_err_div0 <= w_div0;
                r_err_ovf  <= !w_div0;
                r_shift    <= QUOT_SAT;
                r_rem      <= dividend[N-1:0];
            end else begin
                r_rem   <= dividend[2*N-1:N];
                r_shift <= dividend[N-1:0];
            end
        end else if (r_state == CALC) begin
            r_rem   <= w_rem[BITS_PER_CYC];
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
        end else if ((r_state == DONE) && out_ready) begin
            r_err_div0 <= 1'b0;
            r_err_ovf  <= 1'b0;
        end
    end

    assign quotient  = (r_state == DONE) ? r_shift : '0;
    assign remainder = (r_state == DONE) ? r_rem   : '0;
    assign err_div0  = r_err_div0;
    assign err_ovf   = r_err_ovf;

endmodule

// File: doc/mult8_inv_divider.md
Name: mult8_inv_divider

Overview:
- Sequential unsigned divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient + 8-bit remainder.
- Inverse of the 8x8 product path. For any product P = A*B with B != 0, it recovers A as the quotient and 0 as the remainder.
- Resolves 2 quotient bits per cycle, using two chained restoring steps.
- Valid/ready on both input and output, so it sits directly downstream of the multiplier datapath or its checker.

Parameters:
- N, 8, divisor/quotient/remainder width; dividend is 2N.
- BITS_PER_CYC, 2, quotient bits resolved per CALC cycle; must divide N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- dividend  in  2N  unsigned dividend
- divisor  in  N  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- quotient  out  N  unsigned quotient
- remainder  out  N  unsigned remainder
- err_div0  out  1  divisor was zero
- err_ovf  out  1  quotient does not fit in N bits

Behaviour:
- Reset (async, active-high) forces state IDLE.
  - in_ready=1 in IDLE after reset.
  - out_valid=0, quotient=0, remainder=0, err_div0=0, err_ovf=0.
  - All internal registers clear.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture operands.
  - divisor==0 -> DONE with err_div0=1, quotient=all ones, remainder=dividend[N-1:0].
  - else dividend[2N-1:N] >= divisor -> DONE with err_ovf=1, quotient=all ones, remainder=dividend[N-1:0].
  - else -> CALC. Load partial remainder = dividend[2N-1:N], shift register = dividend[N-1:0], iteration counter = 0.
- CALC: in_ready=0. Each cycle applies BITS_PER_CYC restoring steps combinationally.
  - Step: r' = {r, next dividend bit}, width N+1.
  - If r' >= divisor: r = r' - divisor, q bit = 1; else r = r'[N-1:0], q bit = 0.
  - Quotient bits shift in MSB first.
  - After N/BITS_PER_CYC cycles (4 for defaults) -> DONE.
- DONE: out_valid=1. Outputs hold stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready -> IDLE. out_valid drops the next cycle; the error flags clear at the same edge.
  - in_ready=0 in DONE; no input/output overlap.
- Latency from the acceptance edge to out_valid high:
  - normal: N/BITS_PER_CYC + 1 edges (5 for defaults);
  - error: 1 edge.
- Throughput: one division per latency + 1 cycles, with out_ready held high.
- Width rules:
  - Step comparison is N+1 bits wide, so no carry is lost.
  - No operand is sign-interpreted.
  - Remainder is always < divisor on a non-error result.
- in_valid while busy is ignored; operands are not re-sampled. Operand changes during CALC do not affect the result.
- Reset mid-CALC or mid-DONE aborts immediately: outputs go to reset values and no partial result is emitted.
- err_div0 takes priority over err_ovf; never both asserted.

Decomposition:
- Shared package:
  - state enum {IDLE, CALC, DONE};
  - localparam for the iteration count N/BITS_PER_CYC;
  - the all-ones saturation constant for error quotients.
- Sub-module div_restore_step (combinational, one restoring bit). Instantiated BITS_PER_CYC times in a chain inside CALC.

Test Plan:
- Dividend 1000 (0x03E8), divisor 7 -> after 5 cycles, quotient 142 (0x8E), remainder 6, no error flags.
- Dividend 0xFE01, divisor 0xFF -> quotient 0xFF, remainder 0. Then an exhaustive loop over all A,B in 1..255 with dividend=A*B -> quotient A, remainder 0 in every case.
- Dividend 0x1234, divisor 0 -> 1 cycle later: err_div0=1, quotient 0xFF, remainder 0x34, err_ovf=0.
- Dividend 0xFFFF, divisor 0xFF -> err_ovf=1, quotient 0xFF, remainder 0xFF. Dividend 0x0700, divisor 7 -> err_ovf=1.
- Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. A second in_valid in that window is ignored.
- Assert rst on the 2nd CALC cycle of 1000/7 -> out_valid=0 and in_ready=1 after release. Next operation, 255/16 -> quotient 15, remainder 15, unaffected by the aborted operation.
